// File: rtl/mux_path_exerciser.sv
// mux_path_exerciser: stimulus generator and checker for a two-stage buffered mux path.
// Walks {data,sel} through a Gray sequence, lets each vector settle, then checks that
// the path output equals the registered data bit. Mismatches and checked vectors are
// counted with saturation, and a pass flag is produced at the end of each run.
module mux_path_exerciser #(
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_LOOPS     = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             dut_out,
    output logic             dut_data,
    output logic             dut_sel,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count
);

    localparam int NUM_VEC = 4 * NUM_LOOPS;
    localparam int RUN_W   = $clog2(NUM_VEC);
    localparam int WAIT_W  = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [1:0]          vec_idx;
    logic [RUN_W-1:0]    run_idx;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                last_vec;

    // The run length is tracked separately from vec_count so that a narrow,
    // saturating vec_count cannot change how many vectors are applied.
    assign last_vec = (run_idx == RUN_W'(NUM_VEC - 1));

    // State register; reset abandons any run in progress without a done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection and busy decode; busy covers LOAD through the last CHECK.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                busy    = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (wait_cnt == '0) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                busy    = 1'b1;
                state_d = last_vec ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath: vector drive, settle counter, comparison counters and result flags.
    // The compare uses the registered dut_data, so dut_out never reaches an output
    // combinationally. The Gray vector for index i is {i[1], i[1]^i[0]}.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dut_data  <= 1'b0;
            dut_sel   <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            vec_count <= '0;
            vec_idx   <= 2'd0;
            run_idx   <= '0;
            wait_cnt  <= '0;
        end else begin
            done <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        err_count <= '0;
                        vec_count <= '0;
                        pass      <= 1'b0;
                        vec_idx   <= 2'd0;
                        run_idx   <= '0;
                    end
                end
                S_LOAD: begin
                    dut_data <= vec_idx[1];
                    dut_sel  <= vec_idx[1] ^ vec_idx[0];
                    wait_cnt <= WAIT_W'(SETTLE_CYCLES - 1);
                end
                S_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_CHECK: begin
                    if ((dut_out != dut_data) && !(&err_count)) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (!(&vec_count)) begin
                        vec_count <= vec_count + 1'b1;
                    end
                    vec_idx <= vec_idx + 2'd1;
                    run_idx <= run_idx + 1'b1;
                end
                S_DONE: begin
                    pass <= (err_count == '0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_path_exerciser.sv
// Testbench for mux_path_exerciser: models the path under test (ideal, inverting,
// stuck-at-0), scoreboards the applied vectors and checks counts, pass and timing.
module tb_mux_path_exerciser;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       out_a;
    logic       data_a, sel_a, busy_a, done_a, pass_a;
    logic [7:0] err_a, vcnt_a;
    logic       out_b;
    logic       data_b, sel_b, busy_b, done_b, pass_b;
    logic [1:0] err_b, vcnt_b;

    int total;
    int bad;
    int mode;

    logic [1:0] vec_tab [4];
    logic [1:0] exp_q [$];
    logic [1:0] obs_q [$];

    int   done_cyc, done_cnt, done_b_cyc;
    logic busy_c0, busy_c47, busy_c48;
    logic [7:0] fin_err, fin_vcnt;
    logic       fin_pass;
    logic [1:0] fin_err_b, fin_vcnt_b;
    logic       fin_pass_b;
    logic [15:0] abort_snap;

    mux_path_exerciser #(.SETTLE_CYCLES(4), .NUM_LOOPS(2), .CNT_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .dut_out(out_a),
        .dut_data(data_a), .dut_sel(sel_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .vec_count(vcnt_a)
    );

    mux_path_exerciser #(.SETTLE_CYCLES(4), .NUM_LOOPS(2), .CNT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .dut_out(out_b),
        .dut_data(data_b), .dut_sel(sel_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .vec_count(vcnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Path models: instance a switches behaviour by mode, instance b always inverts.
    always_comb begin
        out_a = data_a;
        if (mode == 1) out_a = ~data_a;
        else if (mode == 2) out_a = 1'b0;
        out_b = ~data_b;
    end

    function automatic logic model_out(input int m, input logic d);
        if (m == 1) return ~d;
        if (m == 2) return 1'b0;
        return d;
    endfunction

    function automatic int model_errs(input int m);
        int e = 0;
        for (int k = 0; k < 8; k++)
            if (model_out(m, vec_tab[k % 4][1]) != vec_tab[k % 4][1]) e++;
        return e;
    endfunction

    // Pulses start and watches one run for up to 60 cycles, pushing the expected
    // vectors to the scoreboard and collecting what the exerciser drove.
    task automatic do_run(input int abort_cyc, input int restart_cyc);
        exp_q.delete();
        obs_q.delete();
        done_cyc = -1; done_cnt = 0; done_b_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(vec_tab[k % 4]);
        @(negedge clk);
        start = 1'b0;
        busy_c0 = busy_a;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == abort_cyc) begin
                reset_n = 1'b0;
                #1;
                abort_snap = {data_a, sel_a, busy_a, done_a, pass_a, err_a, vcnt_a[2:0]};
                abort_snap = abort_snap | {12'd0, vcnt_a[7:3] != 5'd0, 3'd0};
                return;
            end
            if (c == restart_cyc) start = 1'b1;
            if (c == restart_cyc + 1) start = 1'b0;
            if ((c % 6 == 3) && (c < 48)) obs_q.push_back({data_a, sel_a});
            if (c == 47) busy_c47 = busy_a;
            if (c == 48) busy_c48 = busy_a;
            if (done_a) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                fin_err = err_a; fin_vcnt = vcnt_a; fin_pass = pass_a;
            end
            if (done_b && done_b_cyc < 0) begin
                done_b_cyc = c;
                fin_err_b = err_b; fin_vcnt_b = vcnt_b; fin_pass_b = pass_b;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start   = 1'b0;
        mode    = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({data_a, sel_a, busy_a, done_a, pass_a, err_a, vcnt_a} !== 21'd0) begin
            bad++;
            $display("[TB] FAIL reset_a: got %b required all zero",
                     {data_a, sel_a, busy_a, done_a, pass_a, err_a, vcnt_a});
        end
        total++;
        if ({data_b, sel_b, busy_b, done_b, pass_b, err_b, vcnt_b} !== 9'd0) begin
            bad++;
            $display("[TB] FAIL reset_b: got %b required all zero",
                     {data_b, sel_b, busy_b, done_b, pass_b, err_b, vcnt_b});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Pops the scoreboard against every observed vector.
    task automatic test_vectors(input string name);
        total++;
        if (obs_q.size() != 8) begin
            bad++;
            $display("[TB] FAIL %s_vec_cnt: got %0d required 8", name, obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [1:0] o, e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL %s_vector: got %b required %b", name, o, e);
            end
        end
    endtask

    task automatic test_ideal;
        mode = 0;
        do_run(-1, -1);
        test_vectors("ideal");
        total++;
        if (done_cyc !== 49 || done_cnt !== 1) begin
            bad++;
            $display("[TB] FAIL ideal_done: got cyc=%0d n=%0d required cyc=49 n=1", done_cyc, done_cnt);
        end
        total++;
        if ({busy_c0, busy_c47, busy_c48} !== 3'b110) begin
            bad++;
            $display("[TB] FAIL ideal_busy: got %b required 110", {busy_c0, busy_c47, busy_c48});
        end
        total++;
        if (fin_err !== 8'(model_errs(0)) || fin_vcnt !== 8'd8 || fin_pass !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ideal_result: got err=%0d vec=%0d pass=%b required err=%0d vec=8 pass=1",
                     fin_err, fin_vcnt, fin_pass, model_errs(0));
        end
    endtask

    task automatic test_invert;
        int e, es;
        mode = 1;
        do_run(-1, -1);
        test_vectors("invert");
        e  = model_errs(1);
        es = (e > 3) ? 3 : e;
        total++;
        if (fin_err !== 8'(e) || fin_vcnt !== 8'd8 || fin_pass !== 1'b0) begin
            bad++;
            $display("[TB] FAIL invert_result: got err=%0d vec=%0d pass=%b required err=%0d vec=8 pass=0",
                     fin_err, fin_vcnt, fin_pass, e);
        end
        total++;
        if (fin_err_b !== 2'(es) || fin_vcnt_b !== 2'd3 || fin_pass_b !== 1'b0 || done_b_cyc !== 49) begin
            bad++;
            $display("[TB] FAIL sat_result: got err=%0d vec=%0d pass=%b cyc=%0d required err=%0d vec=3 pass=0 cyc=49",
                     fin_err_b, fin_vcnt_b, fin_pass_b, done_b_cyc, es);
        end
    endtask

    task automatic test_stuck;
        int e;
        mode = 2;
        do_run(-1, -1);
        test_vectors("stuck");
        e = model_errs(2);
        total++;
        if (fin_err !== 8'(e) || fin_vcnt !== 8'd8 || fin_pass !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stuck_result: got err=%0d vec=%0d pass=%b required err=%0d vec=8 pass=0",
                     fin_err, fin_vcnt, fin_pass, e);
        end
    endtask

    task automatic test_ignored_start;
        mode = 0;
        do_run(-1, 10);
        test_vectors("ignored");
        total++;
        if (done_cyc !== 49 || done_cnt !== 1) begin
            bad++;
            $display("[TB] FAIL ignored_done: got cyc=%0d n=%0d required cyc=49 n=1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_reset_midrun;
        mode = 0;
        do_run(20, -1);
        total++;
        if (abort_snap !== 16'd0 || err_b !== 2'd0 || vcnt_b !== 2'd0 || busy_b !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_outputs: got %b required all zero", abort_snap);
        end
        while (obs_q.size() > 0) begin
            logic [1:0] o, e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL abort_vector: got %b required %b", o, e);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_run(-1, -1);
        test_vectors("restart");
        total++;
        if (done_cyc !== 49 || fin_err !== 8'd0 || fin_vcnt !== 8'd8 || fin_pass !== 1'b1) begin
            bad++;
            $display("[TB] FAIL restart_result: got cyc=%0d err=%0d vec=%0d pass=%b required cyc=49 err=0 vec=8 pass=1",
                     done_cyc, fin_err, fin_vcnt, fin_pass);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vec_tab[0] = 2'b00;
        vec_tab[1] = 2'b01;
        vec_tab[2] = 2'b11;
        vec_tab[3] = 2'b10;
        test_reset();
        test_ideal();
        test_invert();
        test_stuck();
        test_ignored_start();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
